// File: rtl/sram_1rw_param.sv
// sram_1rw_param: parametrised 1RW SRAM model with pipelined reads and post-reset zero-fill.
// Optional per-lane even parity is enabled by defining SRAM_PARITY_EN.
module sram_1rw_param #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_WMASKS     = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int READ_LATENCY   = 1,
  parameter int SPARE_BIT      = 1,
  parameter int CLEAR_ON_RESET = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                              vccd1,
  inout  wire                              vssd1,
`endif
  input  logic                             clk0,
  input  logic                             rstb0,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [NUM_WMASKS-1:0]            wmask0,
  input  logic                             spare_wen0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH+SPARE_BIT-1:0]  din0,
`ifdef SRAM_PARITY_EN
  input  logic                             parity_inject0,
  output logic                             parity_err0,
`endif
  output logic [DATA_WIDTH+SPARE_BIT-1:0]  dout0,
  output logic                             dout_valid0,
  output logic                             busy0
);
  localparam int LANE = DATA_WIDTH / NUM_WMASKS;
  localparam int W = DATA_WIDTH + SPARE_BIT;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
`ifdef SRAM_PARITY_EN
  localparam int PW = NUM_WMASKS;
`else
  localparam int PW = 0;
`endif
  localparam int WT = W + PW;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_lane
    $error("DATA_WIDTH must be an exact multiple of NUM_WMASKS");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..3");
  end
  logic [WT-1:0] mem [RAM_DEPTH];
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic rd_fire, wr_fire, tail_v;
  logic [WT-1:0] wbits, wdata, tail_d;
  assign busy0 = state == CLEAR;
  assign rd_fire = !csb0 && !busy0 && web0;
  assign wr_fire = !csb0 && !busy0 && !web0;
  always_ff @(posedge clk0 or negedge rstb0)
    if (!rstb0) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt <= '0;
    end else if (busy0) begin
      cnt <= cnt + 1'b1;
      state <= cnt == '1 ? IDLE : CLEAR;
    end
  // Word layout: data lanes, then the spare bit, then one parity bit per lane.
  always_comb begin
    wbits = '0;
    wdata = '0;
    wdata[W-1:0] = din0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      wbits[i*LANE +: LANE] = {LANE{wmask0[i]}};
`ifdef SRAM_PARITY_EN
      wbits[W+i] = wmask0[i];
      wdata[W+i] = ^din0[i*LANE +: LANE] ^ parity_inject0;
`endif
    end
    wbits[W-1] = SPARE_BIT != 0 ? spare_wen0 : wmask0[NUM_WMASKS-1];
  end
  always_ff @(posedge clk0)
    if (busy0) mem[cnt] <= '0;
    else if (wr_fire) mem[addr0] <= (mem[addr0] & ~wbits) | (wdata & wbits);
  if (READ_LATENCY == 1) begin : g_lat1
    assign tail_v = rd_fire;
    assign tail_d = mem[addr0];
  end else begin : g_pipe
    logic [READ_LATENCY-2:0] pv;
    logic [WT-1:0] pd [READ_LATENCY-1];
    always_ff @(posedge clk0 or negedge rstb0)
      if (!rstb0) pv <= '0;
      else begin
        pv[0] <= rd_fire;
        for (int k = 1; k < READ_LATENCY - 1; k++) pv[k] <= pv[k-1];
      end
    always_ff @(posedge clk0) begin
      pd[0] <= mem[addr0];
      for (int k = 1; k < READ_LATENCY - 1; k++) pd[k] <= pd[k-1];
    end
    assign tail_v = pv[READ_LATENCY-2];
    assign tail_d = pd[READ_LATENCY-2];
  end
`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] lane_bad;
  always_comb begin
    lane_bad = '0;
    for (int i = 0; i < NUM_WMASKS; i++) lane_bad[i] = tail_d[W+i] ^ (^tail_d[i*LANE +: LANE]);
  end
  always_ff @(posedge clk0 or negedge rstb0)
    if (!rstb0) parity_err0 <= 1'b0;
    else parity_err0 <= tail_v && |lane_bad;
`endif
  always_ff @(posedge clk0 or negedge rstb0)
    if (!rstb0) begin
      dout0 <= '0;
      dout_valid0 <= 1'b0;
    end else begin
      dout_valid0 <= tail_v;
      if (tail_v) dout0 <= tail_d[W-1:0];
    end
endmodule

// File: tb/tb_sram_1rw_param.sv
// tb_sram_1rw_param: directed checks on two instances (16 words / latency 3 and 32 words / latency 2).
module tb_sram_1rw_param;
  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;
  logic rstb0, csb0, web0, spare_wen0;
  logic [7:0] wmask0;
  logic [4:0] addr0;
  logic [64:0] din0, dout_a, dout_b;
  logic dv_a, dv_b, busy_a, busy_b;
`ifdef USE_POWER_PINS
  wire vccd1, vssd1;
`endif
`ifdef SRAM_PARITY_EN
  logic parity_inject0, perr_a, perr_b;
`endif
  int checks = 0, errors = 0;
  logic [64:0] dat [3] = '{65'h1_0000_0000_0000_0001, 65'h0_2222_2222_2222_2222, 65'h1_3333_3333_3333_3333};

  sram_1rw_param #(.ADDR_WIDTH(4), .READ_LATENCY(3)) dut_a (
`ifdef USE_POWER_PINS
    .vccd1(vccd1), .vssd1(vssd1),
`endif
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .spare_wen0(spare_wen0), .addr0(addr0[3:0]), .din0(din0),
`ifdef SRAM_PARITY_EN
    .parity_inject0(parity_inject0), .parity_err0(perr_a),
`endif
    .dout0(dout_a), .dout_valid0(dv_a), .busy0(busy_a));

  sram_1rw_param #(.ADDR_WIDTH(5), .READ_LATENCY(2)) dut_b (
`ifdef USE_POWER_PINS
    .vccd1(vccd1), .vssd1(vssd1),
`endif
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .spare_wen0(spare_wen0), .addr0(addr0), .din0(din0),
`ifdef SRAM_PARITY_EN
    .parity_inject0(parity_inject0), .parity_err0(perr_b),
`endif
    .dout0(dout_b), .dout_valid0(dv_b), .busy0(busy_b));

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [64:0] d, input logic [7:0] m, input logic sw, input logic inj);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; spare_wen0 = sw;
`ifdef SRAM_PARITY_EN
    parity_inject0 = inj;
`else
    if (inj) $display("parity inject ignored without SRAM_PARITY_EN");
`endif
    tick;
    csb0 = 1'b1;
`ifdef SRAM_PARITY_EN
    parity_inject0 = 1'b0;
`endif
    chk("wr_no_strobe", {dv_a, dv_b}, 0);
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [64:0] ea, input logic [64:0] eb, input logic ep);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    tick;
    csb0 = 1'b1;
    chk({tag, "_early"}, {dv_a, dv_b}, 0);
    tick;
    chk({tag, "_dv_b"}, {dv_a, dv_b}, 2'b01);
    chk({tag, "_dout_b"}, dout_b, eb);
`ifdef SRAM_PARITY_EN
    chk({tag, "_perr_b"}, perr_b, ep);
`endif
    tick;
    chk({tag, "_dv_a"}, {dv_a, dv_b}, 2'b10);
    chk({tag, "_dout_a"}, dout_a, ea);
`ifdef SRAM_PARITY_EN
    chk({tag, "_perr_a"}, perr_a, ep);
`else
    if (ep) $display("parity expectation ignored without SRAM_PARITY_EN");
`endif
  endtask

  // A read is attempted on the third posedge of every clear and must be dropped.
  task automatic clear_run(input string tag);
    int n = 0, na = 0;
    logic seen = 1'b0;
    while (busy_b && n < 200) begin
      csb0 = n != 2; web0 = 1'b1; addr0 = 5'd5;
      tick;
      n++;
      if (!busy_a && na == 0) na = n;
      seen |= dv_a | dv_b;
    end
    csb0 = 1'b1;
    chk({tag, "_busy_a"}, na, 16);
    chk({tag, "_busy_b"}, n, 32);
    chk({tag, "_nostrobe"}, seen, 0);
  endtask

  initial begin
    rstb0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; spare_wen0 = 1'b0; addr0 = '0; din0 = '0;
`ifdef SRAM_PARITY_EN
    parity_inject0 = 1'b0;
`endif
    tick;
    tick;
    chk("rst_dout", {dout_a, dout_b}, 0);
    chk("rst_dv", {dv_a, dv_b}, 0);
    chk("rst_busy", {busy_a, busy_b}, 2'b11);
    rstb0 = 1'b1;
    clear_run("clr0");
    rd(5'd5, "rd_clr", 65'h0, 65'h0, 1'b0);
    wr(5'h1A, 65'h1_1122_3344_5566_7788, 8'hFF, 1'b1, 1'b0);
    rd(5'h1A, "rd_full", 65'h1_1122_3344_5566_7788, 65'h1_1122_3344_5566_7788, 1'b0);
    wr(5'h1A, 65'h0_FFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 1'b0);
    rd(5'h1A, "rd_mask", 65'h1_1122_3344_FFFF_FFFF, 65'h1_1122_3344_FFFF_FFFF, 1'b0);
    for (int k = 0; k < 3; k++) wr(5'(k + 1), dat[k], 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      csb0 = i >= 3; web0 = 1'b1; addr0 = 5'(i + 1);
      tick;
      chk("pipe_dv_b", dv_b, i >= 1 && i <= 3);
      chk("pipe_dv_a", dv_a, i >= 2);
      if (i >= 1 && i <= 3) chk("pipe_dout_b", dout_b, dat[i-1]);
      if (i >= 2) chk("pipe_dout_a", dout_a, dat[i-2]);
    end
    csb0 = 1'b1;
    wr(5'd7, 65'hAB, 8'hFF, 1'b1, 1'b0);
    rd(5'd7, "raw", 65'hAB, 65'hAB, 1'b0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 5'd7;
    tick;
    web0 = 1'b0; din0 = 65'h55; wmask0 = 8'hFF; spare_wen0 = 1'b1;
    tick;
    csb0 = 1'b1;
    chk("war_dv_b", dv_b, 1);
    chk("war_dout_b", dout_b, 65'hAB);
    tick;
    chk("war_dv_a", dv_a, 1);
    chk("war_dout_a", dout_a, 65'hAB);
    rd(5'd7, "war_new", 65'h55, 65'h55, 1'b0);
    wr(5'd7, {65{1'b1}}, 8'h00, 1'b0, 1'b0);
    rd(5'd7, "noop", 65'h55, 65'h55, 1'b0);
`ifdef SRAM_PARITY_EN
    wr(5'd3, dat[2], 8'h01, 1'b0, 1'b1);
    rd(5'd3, "par_inj", dat[2], dat[2], 1'b1);
    wr(5'd3, dat[2], 8'h01, 1'b0, 1'b0);
    rd(5'd3, "par_fix", dat[2], dat[2], 1'b0);
`endif
    csb0 = 1'b0; web0 = 1'b1; addr0 = 5'd1;
    tick;
    addr0 = 5'd2;
    tick;
    rstb0 = 1'b0; csb0 = 1'b1;
    #1;
    chk("mid_rst_dout_a", dout_a, 0);
    chk("mid_rst_dout_b", dout_b, 0);
    chk("mid_rst_dv", {dv_a, dv_b}, 0);
    chk("mid_rst_busy", {busy_a, busy_b}, 2'b11);
    tick;
    tick;
    chk("mid_rst_flush", {dv_a, dv_b}, 0);
    rstb0 = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    chk("part_clr_busy", {busy_a, busy_b}, 2'b11);
    rstb0 = 1'b0;
    tick;
    rstb0 = 1'b1;
    clear_run("clr1");
    rd(5'd1, "rd_clr1", 65'h0, 65'h0, 1'b0);
    rd(5'd7, "rd_clr7", 65'h0, 65'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_1rw_param.md
Name: sram_1rw_param

Overview:
- Parametrised successor to the team's fixed 64x512 single-port RW SRAM behavioural model.
- Configurable width, depth, mask-lane count and read latency.
- Fully posedge-synchronous, with a pipelined read path, a dout_valid0 strobe, and a post-reset clear engine that zeroes the array.
- Sits beside the user-project logic as a drop-in memory model for simulation and for small synthesised buffers.

Parameters:
- DATA_WIDTH, 64: data bits per word, excluding the spare bit.
- NUM_WMASKS, 8: write-mask lanes. LANE = DATA_WIDTH/NUM_WMASKS. Elaboration $error if not an exact division.
- ADDR_WIDTH, 9: address bits. RAM_DEPTH = 1<<ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read sample to dout0. Legal range 1..3; $error otherwise.
- SPARE_BIT, 1: 1 adds one spare bit at index DATA_WIDTH, gated by spare_wen0.
- CLEAR_ON_RESET, 1: 1 runs the zero-fill engine after reset.

Ports:
- clk0  in  1  clock; all state changes on posedge.
- rstb0  in  1  asynchronous active-low reset.
- vccd1, vssd1  inout  1  power, present only under USE_POWER_PINS.
- csb0  in  1  active-low chip select.
- web0  in  1  active-low write enable.
- wmask0  in  NUM_WMASKS  lane write enables.
- spare_wen0  in  1  spare-bit write enable; ignored if SPARE_BIT=0.
- addr0  in  ADDR_WIDTH  word address.
- din0  in  DATA_WIDTH+SPARE_BIT  write data.
- dout0  out  DATA_WIDTH+SPARE_BIT  read data.
- dout_valid0  out  1  one-cycle strobe marking fresh dout0.
- busy0  out  1  high while the clear engine runs; accesses are ignored.

Behaviour:
- Reset (rstb0=0, asynchronous):
  - dout0=0, dout_valid0=0, read pipeline flushed.
  - busy0=CLEAR_ON_RESET; state=CLEAR if CLEAR_ON_RESET else IDLE; clear counter=0.
  - Array contents are not touched asynchronously.
- FSM state CLEAR:
  - Each posedge writes all-zero (including spare and parity bits) to address cnt, then cnt++.
  - At cnt==RAM_DEPTH-1 the write completes and the FSM moves to IDLE.
  - busy0 is high for exactly RAM_DEPTH cycles after reset release and is deasserted registered on the transition to IDLE.
- FSM state IDLE: accesses are accepted at posedge when csb0=0 and busy0=0. Accesses while busy0=1 are dropped: no write, no strobe.
- Write (web0=0):
  - Lane i, bits [i*LANE +: LANE], is updated iff wmask0[i].
  - Spare bit is updated iff spare_wen0.
  - wmask0=0 with spare_wen0=0 is a legal no-op.
  - A write does not alter dout0 or dout_valid0.
- Read (web0=1): addr0 is sampled at posedge N. The array is read at N, then staged through READ_LATENCY-1 registers.
  - dout0 is updated and dout_valid0=1 for the cycle following posedge N+READ_LATENCY-1.
  - dout0 holds its last value between reads; it never goes X.
- Throughput and ordering:
  - One access per cycle; back-to-back reads are fully pipelined.
  - A write at N followed by a read of the same address at N+1 returns the new data.
  - A read at N followed by a write at N+1 returns the old data.
- csb0=1: no access; the pipeline still drains in-flight reads.
- Reset mid-clear restarts the clear from address 0. Reset mid-read drops in-flight reads, so no strobe appears.
- The address always maps in range because the depth is a power of two.

Optional Feature:
- Macro name: SRAM_PARITY_EN.
- When defined:
  - Stores NUM_WMASKS extra bits, one even-parity bit per lane, written with its lane.
  - New input parity_inject0 (1 bit): when high on a write, stores inverted parity for the written lanes.
  - New output parity_err0: asserted with dout_valid0 when any lane's parity mismatches, otherwise 0. Reset value 0.
  - The clear engine writes parity 0, which is consistent with zero data.
- When undefined: no parity storage, and neither port exists.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy0 high for exactly 16 cycles; a read of addr 5 issued at cycle 3 produces no strobe; a read after busy0 falls returns 0.
- Write addr 0x1A, din=0x1122334455667788, wmask=0xFF, spare_wen=1, spare=1; read 0x1A at READ_LATENCY=2 -> dout0=0x1_1122334455667788 with dout_valid0 exactly 2 cycles after the read sample.
- Overwrite 0x1A with din=0xFFFF..., wmask=0x0F, spare_wen=0 -> read returns 0x1_11223344FFFFFFFF.
- Reads of addr 1,2,3 on consecutive cycles at READ_LATENCY=3 -> three consecutive strobes in order. Write 0xAB to addr 7 then read 7 the next cycle -> 0xAB.
- Assert rstb0 while two reads are in flight -> no strobe, dout0=0, clear restarts at 0.
- SRAM_PARITY_EN defined: write with parity_inject0=1, wmask=0x01, then read -> parity_err0=1 with the strobe. The same address rewritten normally -> parity_err0=0.
